// File: rtl/bridge_uart_frame_rx_if.sv
// rtl/bridge_uart_frame_rx_if.sv - frame handoff handshake between UART frame receiver and bridge master
interface bridge_uart_frame_rx_if #(
  parameter int FRAME_BYTES = 3
) ();
  logic [8*FRAME_BYTES-1:0] frame_data;
  logic                     frame_valid;
  logic                     frame_ready;

  modport master (output frame_data, output frame_valid, input frame_ready);
  modport slave  (input frame_data, input frame_valid, output frame_ready);
endinterface

// File: rtl/bridge_uart_frame_rx.sv
// rtl/bridge_uart_frame_rx.sv - 8N1 UART receiver assembling fixed-length frames for the bridge master
module bridge_uart_frame_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FRAME_BYTES  = 3,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    uart_rx,
  bridge_uart_frame_rx_if.master  frame,
  output logic                    busy,
  output logic                    frame_err,
  output logic                    timeout_err,
  output logic                    overrun
);
  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int IW       = $clog2(TO_LIMIT);
  localparam int BW       = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TO_LIMIT - 1);
  localparam logic [BW-1:0] SLOT_LAST = BW'(FRAME_BYTES - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, RESYNC} state_t;

  state_t                   state, state_next;
  logic                     rx_meta, rxs;
  logic [CW-1:0]            cnt;
  logic [2:0]               bit_idx;
  logic [7:0]               shreg;
  logic [BW-1:0]            byte_idx;
  logic [IW-1:0]            idle_cnt;
  logic [8*FRAME_BYTES-1:0] part, assembled;
  logic                     cnt_clr, bit_sample, byte_ok, stop_bad;
  logic                     frame_done, buf_free, idle_run, idle_hit;

  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    bit_sample = 1'b0;
    byte_ok    = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      IDLE: if (!rxs) begin
        state_next = START;
        cnt_clr    = 1'b1;
      end
      START: if (cnt == HALF_LAST) begin
        cnt_clr    = 1'b1;
        state_next = rxs ? IDLE : DATA;
      end
      DATA: if (cnt == FULL_LAST) begin
        cnt_clr    = 1'b1;
        bit_sample = 1'b1;
        if (bit_idx == 3'd7) state_next = STOP;
      end
      STOP: if (cnt == FULL_LAST) begin
        cnt_clr = 1'b1;
        if (rxs) begin
          byte_ok    = 1'b1;
          state_next = IDLE;
        end else begin
          stop_bad   = 1'b1;
          state_next = RESYNC;
        end
      end
      RESYNC: if (rxs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The byte just completed is merged into its slot so a finishing frame loads in one edge.
  always_comb begin
    assembled = part;
    assembled[{byte_idx, 3'b000} +: 8] = shreg;
  end

  assign frame_done = byte_ok && (byte_idx == SLOT_LAST);
  assign buf_free   = !frame.frame_valid || frame.frame_ready;
  assign idle_run   = (state == IDLE) && (byte_idx != '0) && rxs;
  assign idle_hit   = idle_run && (idle_cnt == IDLE_LAST);
  assign busy       = (state != IDLE) || (byte_idx != '0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_meta           <= 1'b1;
      rxs               <= 1'b1;
      state             <= IDLE;
      cnt               <= '0;
      bit_idx           <= '0;
      shreg             <= '0;
      byte_idx          <= '0;
      idle_cnt          <= '0;
      part              <= '0;
      frame.frame_data  <= '0;
      frame.frame_valid <= 1'b0;
      frame_err         <= 1'b0;
      timeout_err       <= 1'b0;
      overrun           <= 1'b0;
    end else begin
      rx_meta     <= uart_rx;
      rxs         <= rx_meta;
      state       <= state_next;
      frame_err   <= stop_bad;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;

      if (cnt_clr || state == IDLE || state == RESYNC) cnt <= '0;
      else                                             cnt <= cnt + 1'b1;

      if (state == START)  bit_idx <= '0;
      else if (bit_sample) bit_idx <= bit_idx + 1'b1;

      if (bit_sample) shreg[bit_idx] <= rxs;

      if (idle_run && !idle_hit) idle_cnt <= idle_cnt + 1'b1;
      else                       idle_cnt <= '0;

      if (stop_bad) begin
        byte_idx <= '0;
      end else if (byte_ok) begin
        if (frame_done) begin
          byte_idx <= '0;
        end else begin
          part[{byte_idx, 3'b000} +: 8] <= shreg;
          byte_idx <= byte_idx + 1'b1;
        end
      end else if (idle_hit) begin
        timeout_err <= 1'b1;
        byte_idx    <= '0;
      end

      // A handshake in the completing cycle frees the buffer, so the new frame simply replaces it.
      if (frame_done && buf_free) begin
        frame.frame_data  <= assembled;
        frame.frame_valid <= 1'b1;
      end else if (frame_done) begin
        overrun <= 1'b1;
      end else if (frame.frame_valid && frame.frame_ready) begin
        frame.frame_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_bridge_uart_frame_rx.sv
// tb/tb_bridge_uart_frame_rx.sv - scoreboard bench for bridge_uart_frame_rx with directed frames
module tb_bridge_uart_frame_rx;
  localparam int CPB = 8;
  localparam int FB  = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic uart_rx = 1'b1;
  logic busy, frame_err, timeout_err, overrun;

  int tests = 0;
  int fails = 0;
  int n_ferr = 0, n_terr = 0, n_ovr = 0, n_frames = 0;
  logic [23:0] exp_q[$];

  bridge_uart_frame_rx_if #(.FRAME_BYTES(FB)) fif ();

  bridge_uart_frame_rx #(.CLKS_PER_BIT(CPB), .FRAME_BYTES(FB), .TIMEOUT_BITS(20)) dut (
    .clk(clk), .rstn(rstn), .uart_rx(uart_rx), .frame(fif.master),
    .busy(busy), .frame_err(frame_err), .timeout_err(timeout_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted frame and tallies error pulses.
  always @(negedge clk) begin
    if (rstn) begin
      if (frame_err)   n_ferr++;
      if (timeout_err) n_terr++;
      if (overrun)     n_ovr++;
      if (fif.frame_valid && fif.frame_ready) begin
        n_frames++;
        if (exp_q.size() == 0) check("unexpected_frame", {8'h0, fif.frame_data}, 32'hFFFFFFFF);
        else check("frame_data", {8'h0, fif.frame_data}, {8'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    wait_clk(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_clk(CPB);
    end
    uart_rx = stop;
    wait_clk(CPB);
    uart_rx = 1'b1;
  endtask

  task automatic check_zero_outputs(input string tag);
    @(negedge clk);
    check({tag, "_valid"}, {31'b0, fif.frame_valid}, 32'h0);
    check({tag, "_data"}, {8'h0, fif.frame_data}, 32'h0);
    check({tag, "_busy_err"}, {28'b0, busy, frame_err, timeout_err, overrun}, 32'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, e0, t0, o0, bc;
    fif.frame_ready = 1'b1;
    wait_clk(3);
    check_zero_outputs("reset");
    rstn = 1'b1;
    wait_clk(4);

    // 1: basic frame
    f0 = n_frames; e0 = n_ferr; t0 = n_terr; o0 = n_ovr;
    exp_q.push_back(24'h013CA5);
    send_byte(8'hA5, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'h01, 1'b1);
    wait_clk(10);
    check("t1_frames", n_frames - f0, 1);
    check("t1_errors", (n_ferr - e0) + (n_terr - t0) + (n_ovr - o0), 0);

    // 2: overrun while buffer held
    fif.frame_ready = 1'b0;
    o0 = n_ovr; f0 = n_frames;
    exp_q.push_back(24'h332211);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1); send_byte(8'h55, 1'b1); send_byte(8'h66, 1'b1);
    wait_clk(10);
    check("t2_valid_held", {31'b0, fif.frame_valid}, 1);
    check("t2_data_held", {8'h0, fif.frame_data}, 32'h332211);
    check("t2_overrun", n_ovr - o0, 1);
    fif.frame_ready = 1'b1;
    wait_clk(4);
    check("t2_frames", n_frames - f0, 1);
    check("t2_valid_clear", {31'b0, fif.frame_valid}, 0);

    // 3: bad stop bit then good frame
    e0 = n_ferr;
    send_byte(8'h11, 1'b0);
    wait_clk(2 * CPB);
    exp_q.push_back(24'h030201);
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h03, 1'b1);
    wait_clk(10);
    check("t3_frame_err", n_ferr - e0, 1);

    // 4: inter-byte timeout
    t0 = n_terr; f0 = n_frames;
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
    wait_clk(200);
    check("t4_timeout", n_terr - t0, 1);
    check("t4_idle_busy", {31'b0, busy}, 0);
    exp_q.push_back(24'h0C0B0A);
    send_byte(8'h0A, 1'b1); send_byte(8'h0B, 1'b1); send_byte(8'h0C, 1'b1);
    wait_clk(10);
    check("t4_frames", n_frames - f0, 1);

    // 5: short glitch on idle line
    e0 = n_ferr; t0 = n_terr; f0 = n_frames; bc = 0;
    uart_rx = 1'b0;
    wait_clk(2);
    uart_rx = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (busy) bc++;
    end
    check("t5_busy_window", {31'b0, (bc >= 1 && bc <= 6)}, 1);
    check("t5_no_events", (n_ferr - e0) + (n_terr - t0) + (n_frames - f0), 0);

    // 6: reset in the middle of the second byte
    e0 = n_ferr; t0 = n_terr; o0 = n_ovr;
    send_byte(8'h55, 1'b1);
    uart_rx = 1'b0;
    wait_clk(3 * CPB);
    rstn = 1'b0;
    uart_rx = 1'b1;
    wait_clk(1);
    check_zero_outputs("t6_reset");
    wait_clk(2);
    rstn = 1'b1;
    wait_clk(4);
    exp_q.push_back(24'h998877);
    send_byte(8'h77, 1'b1); send_byte(8'h88, 1'b1); send_byte(8'h99, 1'b1);
    wait_clk(10);
    check("t6_errors", (n_ferr - e0) + (n_terr - t0) + (n_ovr - o0), 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
